// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and key-code helper for the keypad scanner
package keypad_pkg;

    localparam int unsigned KP_N = 4;
    localparam logic [5:0] KEY_NONE = 6'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_PRESSED,
        ST_RELEASING
    } kp_state_e;

    // Key code is col*4 + row + 1, so 0 stays free to mean "no key".
    function automatic logic [5:0] key_code(input logic [1:0] col, input logic [1:0] row);
        return {2'b00, col, row} + 6'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all ones (idle level of pulled-up lines)
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with ghost rejection and press/release debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       Clock,
    input  logic       Reset_n,
    output logic [3:0] Kp_Col_O,
    input  logic [3:0] Kp_Row_I,
    output logic [5:0] Keyb_Value,
    output logic       Key_Strobe
);

    localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB       = 4'(DEBOUNCE_SCANS);

    logic [3:0]  row_sync;

    logic [15:0] slot_q, slot_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  col_q, col_d;
    logic [1:0]  hits_q, hits_d;
    logic [5:0]  acc_code_q, acc_code_d;

    kp_state_e   state_q, state_d;
    logic [5:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  value_q, value_d;
    logic        strobe_q, strobe_d;

    logic        slot_end;
    logic        scan_end;
    logic [1:0]  hits_merged;
    logic [5:0]  code_merged;
    logic [5:0]  result;
    logic [3:0]  cnt_inc;

    sync_2ff #(
        .WIDTH (KP_N)
    ) u_row_sync (
        .clk_i  (Clock),
        .rst_ni (Reset_n),
        .d_i    (Kp_Row_I),
        .q_o    (row_sync)
    );

    // Slot timing, column stepping and per-scan accumulation of low rows.
    always_comb begin
        slot_end    = (slot_q == SLOT_LAST);
        scan_end    = slot_end && (col_idx_q == 2'd3);
        hits_merged = hits_q;
        code_merged = acc_code_q;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                if (hits_merged != 2'd2) begin
                    hits_merged = hits_merged + 2'd1;
                end
                code_merged = key_code(col_idx_q, 2'(r));
            end
        end
        // Exactly one closed contact per scan; none or several both read as no key.
        result = (hits_merged == 2'd1) ? code_merged : KEY_NONE;

        slot_d     = slot_end ? 16'd0 : slot_q + 16'd1;
        col_idx_d  = slot_end ? col_idx_q + 2'd1 : col_idx_q;
        col_d      = ~(4'b0001 << col_idx_d);
        hits_d     = hits_q;
        acc_code_d = acc_code_q;
        if (slot_end) begin
            if (scan_end) begin
                hits_d     = 2'd0;
                acc_code_d = KEY_NONE;
            end else begin
                hits_d     = hits_merged;
                acc_code_d = code_merged;
            end
        end
    end

    // Scan datapath registers; the column drive is a flop so rows never reach it combinationally.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_q     <= 16'd0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            hits_q     <= 2'd0;
            acc_code_q <= KEY_NONE;
        end else begin
            slot_q     <= slot_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            hits_q     <= hits_d;
            acc_code_q <= acc_code_d;
        end
    end

    // Debounce FSM, advanced only once per completed scan.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        strobe_d = 1'b0;
        cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (result != KEY_NONE) begin
                        cand_d = result;
                        cnt_d  = 4'd1;
                        if (DEB == 4'd1) begin
                            state_d  = ST_PRESSED;
                            value_d  = result;
                            strobe_d = 1'b1;
                        end else begin
                            state_d = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (result == KEY_NONE) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else if (result == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            state_d  = ST_PRESSED;
                            value_d  = cand_q;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        cand_d = result;
                        cnt_d  = 4'd1;
                    end
                end
                ST_PRESSED: begin
                    if (result != value_q) begin
                        cnt_d = 4'd1;
                        if (DEB == 4'd1) begin
                            state_d = ST_IDLE;
                            value_d = KEY_NONE;
                        end else begin
                            state_d = ST_RELEASING;
                        end
                    end
                end
                ST_RELEASING: begin
                    if (result == value_q) begin
                        state_d = ST_PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            state_d = ST_IDLE;
                            value_d = KEY_NONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Debounce state registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cand_q   <= KEY_NONE;
            cnt_q    <= 4'd0;
            value_q  <= KEY_NONE;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            strobe_q <= strobe_d;
        end
    end

    assign Kp_Col_O   = col_q;
    assign Keyb_Value = value_q;
    assign Key_Strobe = strobe_q;

endmodule
